// File: rtl/pipe_stage_ctl_if.sv
// Data-memory handshake between the pipeline control chain and memory.
// master = pipeline side (raises mem_req), slave = memory (returns mem_ack).
interface pipe_stage_ctl_if;
  logic mem_req;
  logic mem_ack;

  modport master (
    output mem_req,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    output mem_ack
  );
endinterface

// File: rtl/pipe_stage_ctl.sv
// ID->EXE->MEM->WB control chain with load-use bubble and memory freeze.
// Define PIPECTL_MEMWAIT_EN to build the wait-state FSM, timeout and freeze.
module pipe_stage_ctl #(
  parameter int WAIT_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nostall,
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        dwmem,
  input  logic        djal,
  input  logic        daluimm,
  input  logic        dshift,
  input  logic [3:0]  daluc,
  input  logic [4:0]  drn,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ejal,
  output logic        ealuimm,
  output logic        eshift,
  output logic [3:0]  ealuc,
  output logic [4:0]  ern,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrn,
  output logic        freeze,
  output logic        mem_err,
  pipe_stage_ctl_if.master mem
);

  logic req;

  assign req = mm2reg | mwmem;
  assign mem.mem_req = req;

  // While frozen E and M hold; W takes a bubble so MEM retires once.
  always_ff @(posedge clock) begin
    if (reset) begin
      {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern} <= '0;
      {mwreg, mm2reg, mwmem, mrn} <= '0;
      {wwreg, wm2reg, wrn} <= '0;
    end else if (!freeze) begin
      if (nostall) begin
        {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern} <=
          {dwreg, dm2reg, dwmem, djal, daluimm, dshift, daluc, drn};
      end else begin
        {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern} <= '0;
      end
      {mwreg, mm2reg, mwmem, mrn} <= {ewreg, em2reg, ewmem, ern};
      {wwreg, wm2reg, wrn} <= {mwreg, mm2reg, mrn};
    end else begin
      {wwreg, wm2reg, wrn} <= '0;
    end
  end

`ifdef PIPECTL_MEMWAIT_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;
  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              ack;

  assign ack = mem.mem_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter saturates; ERR is taken as it reaches CNT_MAX.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req && !ack) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (req && ack) begin
          state_nxt = S_IDLE;
        end else begin
          if (cnt == CNT_MAX - CNT_ONE) state_nxt = S_ERR;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    freeze  = 1'b0;
    mem_err = 1'b0;
    if (state == S_ERR) begin
      freeze  = 1'b1;
      mem_err = 1'b1;
    end else begin
      freeze = req & ~ack;
    end
  end
`else
  logic              unused_ack;
  logic [WAIT_W-1:0] unused_cnt;

  assign unused_ack = mem.mem_ack;
  assign unused_cnt = '0;
  assign freeze     = 1'b0;
  assign mem_err    = 1'b0;
`endif

endmodule
